promote_menu_ctrl: RTL

- Controls the pawn-promotion overlay: accepts a promotion request, runs the piece-selection menu from keyboard pulses, and reports the chosen piece to the game logic.
- Sequences the promotion sprite ROM for the raster: converts DrawX/DrawY to a ROM address and delay-aligns the per-pixel control with the ROM read.
- Drives the 4-bit index into the 16-entry grayscale promote palette, plus overlay-enable and highlight flags, to the colour mapper.

---
 rtl/promote_menu_ctrl_pkg.sv | 33 +++
 rtl/promote_sprite_addr.sv | 45 ++++
 rtl/promote_menu_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/promote_menu_ctrl_pkg.sv
// Shared chess definitions: piece encoding, promotion-menu states and screen geometry.
package promote_menu_ctrl_pkg;

    typedef enum logic [1:0] {
        QUEEN  = 2'd0,
        ROOK   = 2'd1,
        BISHOP = 2'd2,
        KNIGHT = 2'd3
    } piece_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        DONE = 2'd2
    } menu_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COORD_W  = 10;

    // Left/right in the same cycle cancel; otherwise step with wrap-around.
    function automatic piece_t step_sel(input piece_t sel, input logic left, input logic right);
        piece_t result;
        result = sel;
        if (right && !left) begin
            result = piece_t'(sel + 2'd1);
        end else if (left && !right) begin
            result = piece_t'(sel - 2'd1);
        end
        return result;
    endfunction

endpackage

// File: rtl/promote_sprite_addr.sv
// Maps a raster position to the four-tile promotion sprite: box hit, tile number, ROM address.
module promote_sprite_addr
    import promote_menu_ctrl_pkg::*;
#(
    parameter int MENU_X = 224,
    parameter int MENU_Y = 208,
    parameter int TILE_W = 48,
    parameter int TILE_H = 48,
    parameter int ROM_AW = 14
) (
    input  logic [COORD_W-1:0] draw_x,
    input  logic [COORD_W-1:0] draw_y,
    output logic               in_box,
    output logic [1:0]         tile,
    output logic [ROM_AW-1:0]  rom_addr
);

    localparam logic [COORD_W-1:0] X_LO = COORD_W'(MENU_X);
    localparam logic [COORD_W-1:0] X_HI = COORD_W'(MENU_X + 4 * TILE_W);
    localparam logic [COORD_W-1:0] Y_LO = COORD_W'(MENU_Y);
    localparam logic [COORD_W-1:0] Y_HI = COORD_W'(MENU_Y + TILE_H);

    logic [COORD_W-1:0] rx;
    logic [COORD_W-1:0] ry;

    // Bounds are checked before subtracting, so rx/ry never underflow.
    always_comb begin
        in_box   = (draw_x >= X_LO) && (draw_x < X_HI) && (draw_y >= Y_LO) && (draw_y < Y_HI);
        rx       = '0;
        ry       = '0;
        tile     = 2'd0;
        rom_addr = '0;
        if (in_box) begin
            rx = draw_x - X_LO;
            ry = draw_y - Y_LO;
            for (int i = 1; i < 4; i++) begin
                if (rx >= COORD_W'(i * TILE_W)) begin
                    tile = 2'(i);
                end
            end
            rom_addr = ROM_AW'(ry) * ROM_AW'(4 * TILE_W) + ROM_AW'(rx);
        end
    end

endmodule

// File: rtl/promote_menu_ctrl.sv
// Pawn-promotion overlay: keyboard-driven piece menu plus sprite ROM sequencing for the raster.
module promote_menu_ctrl
    import promote_menu_ctrl_pkg::*;
#(
    parameter int         MENU_X     = 224,
    parameter int         MENU_Y     = 208,
    parameter int         TILE_W     = 48,
    parameter int         TILE_H     = 48,
    parameter int         ROM_AW     = 14,
    parameter int         ROM_LAT    = 1,
    parameter logic [3:0] TRANSP_IDX = 4'd13
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               promo_req,
    input  logic               promo_color,
    input  logic               key_left,
    input  logic               key_right,
    input  logic               key_enter,
    input  logic               frame_start,
    input  logic [COORD_W-1:0] DrawX,
    input  logic [COORD_W-1:0] DrawY,
    output logic [ROM_AW-1:0]  rom_addr,
    input  logic [3:0]         rom_data,
    output logic [3:0]         pal_index,
    output logic               overlay_en,
    output logic               highlight,
    output logic               busy,
    output logic               promo_done,
    output logic [1:0]         promo_piece,
    output logic               promo_side
);

    menu_state_t state_q, state_d;
    piece_t      sel_q, sel_d;
    piece_t      piece_q, piece_d;
    piece_t      disp_sel_q, disp_sel_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        side_q, side_d;
    logic        disp_active_q, disp_active_d;
    logic [3:0]  pal_q, pal_d;
    logic        ovl_q, ovl_d;
    logic        hl_q, hl_d;

    logic [ROM_LAT-1:0] vis_pipe_q, vis_pipe_d;
    logic [ROM_LAT-1:0] match_pipe_q, match_pipe_d;

    logic       in_box;
    logic [1:0] tile;

    promote_sprite_addr #(
        .MENU_X (MENU_X),
        .MENU_Y (MENU_Y),
        .TILE_W (TILE_W),
        .TILE_H (TILE_H),
        .ROM_AW (ROM_AW)
    ) u_addr (
        .draw_x   (DrawX),
        .draw_y   (DrawY),
        .in_box   (in_box),
        .tile     (tile),
        .rom_addr (rom_addr)
    );

    // Per-pixel control rides alongside the ROM read so it lines up with rom_data.
    assign vis_pipe_d[0]   = in_box & disp_active_q;
    assign match_pipe_d[0] = (tile == disp_sel_q);

    genvar gi;
    generate
        for (gi = 1; gi < ROM_LAT; gi++) begin : g_align
            assign vis_pipe_d[gi]   = vis_pipe_q[gi-1];
            assign match_pipe_d[gi] = match_pipe_q[gi-1];
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        piece_d       = piece_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        side_d        = side_q;
        disp_sel_d    = disp_sel_q;
        disp_active_d = disp_active_q;

        case (state_q)
            IDLE: begin
                if (promo_req) begin
                    side_d  = promo_color;
                    sel_d   = QUEEN;
                    state_d = SHOW;
                    busy_d  = 1'b1;
                end
            end
            SHOW: begin
                if (key_enter) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    piece_d = sel_q;
                end else begin
                    sel_d = step_sel(sel_q, key_left, key_right);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Display copies only move at vblank so the overlay never tears.
        if (frame_start) begin
            disp_sel_d    = sel_q;
            disp_active_d = busy_q;
        end

        pal_d = rom_data;
        ovl_d = vis_pipe_q[ROM_LAT-1] & (rom_data != TRANSP_IDX);
        hl_d  = ovl_d & match_pipe_q[ROM_LAT-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            sel_q         <= QUEEN;
            piece_q       <= QUEEN;
            disp_sel_q    <= QUEEN;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            side_q        <= 1'b0;
            disp_active_q <= 1'b0;
            vis_pipe_q    <= '0;
            match_pipe_q  <= '0;
            pal_q         <= 4'd0;
            ovl_q         <= 1'b0;
            hl_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            piece_q       <= piece_d;
            disp_sel_q    <= disp_sel_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            side_q        <= side_d;
            disp_active_q <= disp_active_d;
            vis_pipe_q    <= vis_pipe_d;
            match_pipe_q  <= match_pipe_d;
            pal_q         <= pal_d;
            ovl_q         <= ovl_d;
            hl_q          <= hl_d;
        end
    end

    assign pal_index   = pal_q;
    assign overlay_en  = ovl_q;
    assign highlight   = hl_q;
    assign busy        = busy_q;
    assign promo_done  = done_q;
    assign promo_piece = piece_q;
    assign promo_side  = side_q;

endmodule
